uart_rx_fifo: RTL and testbench

//  Downstream stage of the UART receiver: captures each received byte into a FIFO and exposes it
//  to the CPU through a small register port. The FIFO decouples CPU read latency from line rate.
//  It flags overflow and raises a level interrupt when the fill level reaches a programmable

---
 rtl/uart_rx_fifo_pkg.sv | 12 +
 rtl/uart_rx_fifo_sync_fifo.sv | 39 +++
 rtl/uart_rx_fifo.sv | 52 +++++
 tb/tb_uart_rx_fifo.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: register map, bit positions and helpers shared by the UART RX path
package uart_rx_fifo_pkg;
  localparam int UART_DATA_W = 8;
  localparam logic [1:0] UART_RX_DATA = 2'd0;
  localparam logic [1:0] UART_RX_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_CTRL = 2'd2;
  localparam int STAT_OVF_BIT = 8;
  localparam int CTRL_IE_BIT = 8;
  function automatic logic [7:0] eff_thr(input logic [7:0] thr);
    return thr == 8'd0 ? 8'd1 : thr;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, shared by the UART RX and TX paths
// ports: clk/RSTn, push/din write side, pop/dout read side (dout shows head entry),
//        count (0..2**AW), full, empty
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign pop_ok = pop & ~empty;
  // a same-cycle pop frees a slot, so a push into a full FIFO still lands
  assign push_ok = push & (~full | pop_ok);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers received UART bytes and exposes them through a DATA/STATUS/CTRL register port
// ports: clk/RSTn, rx_data/rx_done from the deserializer, sel/we/addr/wdata/rdata register
//        port (single-cycle access, rdata combinational), irq registered level interrupt
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_done,
  input  logic                   sel,
  input  logic                   we,
  input  logic [1:0]             addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   irq
);
  logic rx_done_d, push, pop, full, empty, ovf, ctrl_ie;
  logic [7:0] ctrl_thr;
  logic [UART_DATA_W-1:0] dout;
  logic [DEPTH_LOG2:0] count;
  logic [8:0] cnt9;
  logic unused;
  sync_fifo #(.DW(UART_DATA_W), .AW(DEPTH_LOG2)) u_fifo (
    .clk(clk), .RSTn(RSTn), .push(push), .pop(pop), .din(rx_data),
    .dout(dout), .count(count), .full(full), .empty(empty)
  );
  assign push = rx_done & ~rx_done_d;
  assign pop = sel & ~we & (addr == UART_RX_DATA) & ~empty;
  assign cnt9 = 9'(count);
  assign unused = ^{wdata[31:9], cnt9[8]};
  assign rdata = addr == UART_RX_DATA ? (empty ? 32'd0 : {24'd0, dout})
               : addr == UART_RX_STATUS ? {23'd0, ovf, cnt9[7:0]}
               : addr == UART_RX_CTRL ? {23'd0, ctrl_ie, ctrl_thr} : 32'd0;
  // rx_done_d resets high so a level already asserted out of reset is not taken as a new frame
  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      rx_done_d <= 1'b1;
      ovf <= 1'b0;
      ctrl_thr <= 8'd1;
      ctrl_ie <= 1'b0;
      irq <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      ovf <= (push & full & ~pop) | (ovf & ~(sel & we & addr == UART_RX_STATUS & wdata[STAT_OVF_BIT]));
      ctrl_thr <= sel & we & addr == UART_RX_CTRL ? wdata[7:0] : ctrl_thr;
      ctrl_ie <= sel & we & addr == UART_RX_CTRL ? wdata[CTRL_IE_BIT] : ctrl_ie;
      irq <= ctrl_ie & ((cnt9 >= {1'b0, eff_thr(ctrl_thr)}) | ovf);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  logic clk = 0, RSTn = 0, rx_done = 1, sel = 0, we = 0, irq;
  logic [7:0] rx_data = 0;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0, rdata;
  int n_chk = 0, n_err = 0;
  logic [7:0] q[$];
  logic m_ovf = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_done(rx_done), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b);
    rx_data = b;
    rx_done = 1;
    if (q.size() < 16) q.push_back(b);
    else m_ovf = 1;
    tick();
    rx_done = 0;
    tick();
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] e;
    sel = 1; we = 0; addr = 2'd0;
    #1;
    e = 32'd0;
    if (q.size() > 0) e = {24'd0, q.pop_front()};
    chk(tag, rdata, e);
    tick();
    sel = 0;
  endtask

  task automatic chk_status(input string tag);
    addr = 2'd1;
    #1;
    chk(tag, rdata, {23'd0, m_ovf, 8'(q.size())});
  endtask

  task automatic chk_ctrl(input string tag, input logic [31:0] exp);
    addr = 2'd2;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    tick();
    sel = 0; we = 0;
  endtask

  initial begin
    repeat (2) tick();
    RSTn = 1;
    repeat (3) tick();
    chk_status("rst_status");
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk_ctrl("rst_ctrl", 32'h001);
    rx_done = 0;
    tick();

    frame(8'h11); frame(8'h22); frame(8'h33);
    chk_status("t2_status3");
    for (int i = 0; i < 4; i++) rd_data("t2_data");
    chk_status("t2_status0");

    for (int i = 1; i <= 17; i++) frame(8'(i));
    chk_status("t3_full_ovf");
    rx_data = 8'h99; rx_done = 1; sel = 1; we = 1; addr = 2'd1; wdata = 32'h100;
    m_ovf = 1;
    tick();
    sel = 0; we = 0; rx_done = 0;
    tick();
    chk_status("t3_set_wins");
    wr_reg(2'd1, 32'h100);
    m_ovf = 0;
    chk_status("t3_ovf_clr");
    for (int i = 0; i < 16; i++) rd_data("t3_data");
    chk_status("t3_drained");

    for (int i = 0; i < 16; i++) frame(8'(8'h40 + i));
    chk_status("t4_full");
    rx_data = 8'hAA; rx_done = 1; sel = 1; we = 0; addr = 2'd0;
    #1;
    chk("t4_pop", rdata, {24'd0, q.pop_front()});
    q.push_back(8'hAA);
    tick();
    rx_done = 0; sel = 0;
    tick();
    chk_status("t4_no_ovf");
    for (int i = 0; i < 16; i++) rd_data("t4_data");

    wr_reg(2'd2, 32'h104);
    chk_ctrl("t5_ctrl", 32'h104);
    frame(8'h01); frame(8'h02); frame(8'h03);
    chk("t5_irq_below", {31'd0, irq}, 32'd0);
    rx_data = 8'h04; rx_done = 1; q.push_back(8'h04);
    tick();
    chk("t5_irq_latency", {31'd0, irq}, 32'd0);
    tick();
    chk("t5_irq_set", {31'd0, irq}, 32'd1);
    rx_done = 0;
    tick();
    rd_data("t5_pop");
    chk("t5_irq_hold", {31'd0, irq}, 32'd1);
    tick();
    chk("t5_irq_clr", {31'd0, irq}, 32'd0);
    wr_reg(2'd2, 32'h100);
    tick();
    chk("t5_thr0", {31'd0, irq}, 32'd1);
    wr_reg(2'd2, 32'h111);
    tick();
    chk("t5_thr_high", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 3; i++) rd_data("t5_data");

    wr_reg(2'd2, 32'h101);
    rx_data = 8'h5A; rx_done = 1; q.push_back(8'h5A);
    repeat (50) tick();
    chk_status("t6_one_push");
    chk("t6_irq", {31'd0, irq}, 32'd1);
    #2 RSTn = 0;
    q.delete();
    m_ovf = 0;
    #1;
    chk_status("t6_rst_count");
    chk("t6_rst_irq", {31'd0, irq}, 32'd0);
    chk_ctrl("t6_rst_ctrl", 32'h001);
    tick();
    RSTn = 1;
    repeat (3) tick();
    chk_status("t6_no_push");
    rx_done = 0;
    tick();
    rd_data("t6_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
